// File: rtl/hdmi_tx_fmt_gen.sv
// Parallel-RGB video source: H/V timing, FIFO pixel fetch, format select, underflow flag.
// Latency 2 clocks counter-to-pins; no backpressure (timing never stalls, FIFO underrun shows black).
module hdmi_tx_fmt_gen #(
   parameter int H_ACTIVE = 1920,
   parameter int H_FP     = 88,
   parameter int H_SYNC   = 44,
   parameter int H_BP     = 148,
   parameter int V_ACTIVE = 1080,
   parameter int V_FP     = 4,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 36,
   parameter int SYNC_POL = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [1:0]  fmt_mode,
   output logic        fifo_rd_en,
   input  logic [15:0] fifo_rd_data,
   input  logic        fifo_empty,
   input  logic        underflow_clr,
   output logic        underflow,
   output logic        frame_start,
   output logic        hs,
   output logic        vs,
   output logic        de,
   output logic [7:0]  rgb_r,
   output logic [7:0]  rgb_g,
   output logic [7:0]  rgb_b
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int PW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic       fs;
      logic       uf;
      logic [1:0] mode;
      logic [2:0] bar;
   } s1_t;

   logic          en_q;
   logic          run;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_last;
   logic          v_last;
   logic          de0;
   logic          hs0;
   logic          vs0;
   logic          fs0;
   logic [1:0]    mode_q;
   logic [PW-1:0] px_cnt;
   logic [2:0]    bar_idx;
   s1_t           s1;
   logic [23:0]   rgb_nxt;

   function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
      case (idx)
         3'd0:    return 24'hFFFFFF;
         3'd1:    return 24'hFFFF00;
         3'd2:    return 24'h00FFFF;
         3'd3:    return 24'h00FF00;
         3'd4:    return 24'hFF00FF;
         3'd5:    return 24'hFF0000;
         3'd6:    return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   // Registered enable makes a rising enable start the frame at (0,0) on the following clock.
   assign run    = en_q && enable;
   assign h_last = (h_cnt == HW'(H_TOTAL - 1));
   assign v_last = (v_cnt == VW'(V_TOTAL - 1));
   assign de0    = run && (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
   assign hs0    = run && (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
   assign vs0    = run && (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
   assign fs0    = de0 && (h_cnt == '0) && (v_cnt == '0);
   assign fifo_rd_en = de0 && !mode_q[1];

   // mode_q loads on the edge entering (0,0) so the whole frame, pixel (0,0) included, sees one mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q   <= 1'b0;
         h_cnt  <= '0;
         v_cnt  <= '0;
         mode_q <= 2'd0;
      end else begin
         en_q <= enable;
         if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
         end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
         if (!run || (h_last && v_last))
            mode_q <= fmt_mode;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_cnt  <= '0;
         bar_idx <= 3'd0;
      end else if (!de0) begin
         px_cnt  <= '0;
         bar_idx <= 3'd0;
      end else if (px_cnt == PW'(BAR_W - 1)) begin
         px_cnt  <= '0;
         bar_idx <= bar_idx + 3'd1;
      end else begin
         px_cnt  <= px_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
      end else begin
         s1.de   <= de0;
         s1.hs   <= hs0;
         s1.vs   <= vs0;
         s1.fs   <= fs0;
         s1.uf   <= fifo_rd_en && fifo_empty;
         s1.mode <= mode_q;
         s1.bar  <= bar_idx;
      end
   end

   always_comb begin
      rgb_nxt = 24'h000000;
      if (s1.de && !s1.uf) begin
         case (s1.mode)
            2'd0:    rgb_nxt = {fifo_rd_data[15:11], 3'b000, fifo_rd_data[10:5], 2'b00,
                                fifo_rd_data[4:0], 3'b000};
            2'd1:    rgb_nxt = {3{fifo_rd_data[7:0]}};
            2'd2:    rgb_nxt = bar_rgb(s1.bar);
            default: rgb_nxt = 24'h000000;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de                    <= 1'b0;
         hs                    <= (SYNC_POL == 0);
         vs                    <= (SYNC_POL == 0);
         frame_start           <= 1'b0;
         {rgb_r, rgb_g, rgb_b} <= 24'h000000;
         underflow             <= 1'b0;
      end else begin
         de                    <= s1.de;
         hs                    <= (s1.hs == (SYNC_POL != 0));
         vs                    <= (s1.vs == (SYNC_POL != 0));
         frame_start           <= s1.fs;
         {rgb_r, rgb_g, rgb_b} <= rgb_nxt;
         if (s1.uf)
            underflow <= 1'b1;
         else if (underflow_clr)
            underflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_hdmi_tx_fmt_gen.sv
// Directed bench for hdmi_tx_fmt_gen on a 14x7 raster; per-cycle output model keyed on output position.
module tb_hdmi_tx_fmt_gen;
   localparam int H_T = 14;
   localparam int F_T = 98;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [1:0]  fmt_mode;
   logic        fifo_rd_en;
   logic [15:0] fifo_rd_data;
   logic        fifo_empty;
   logic        underflow_clr;
   logic        underflow;
   logic        frame_start;
   logic        hs;
   logic        vs;
   logic        de;
   logic [7:0]  rgb_r;
   logic [7:0]  rgb_g;
   logic [7:0]  rgb_b;

   always #5 clk = ~clk;

   hdmi_tx_fmt_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .fmt_mode(fmt_mode),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
      .underflow_clr(underflow_clr), .underflow(underflow), .frame_start(frame_start),
      .hs(hs), .vs(vs), .de(de), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b)
   );

   logic [15:0] dtab  [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF,
                              16'h1234, 16'h8410, 16'hA5A5, 16'h1255};
   logic [23:0] e565  [8] = '{24'hF80000, 24'h00FC00, 24'h0000F8, 24'hF8FCF8,
                              24'h1044A0, 24'h808080, 24'hA0B428, 24'h1048A8};
   logic [23:0] egray [8] = '{24'h000000, 24'hE0E0E0, 24'h1F1F1F, 24'hFFFFFF,
                              24'h343434, 24'h101010, 24'hA5A5A5, 24'h555555};
   logic [23:0] ebar  [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

   int checks = 0;
   int errors = 0;
   int ppos;
   int uf_target;
   int last_fs;
   int rd_h;
   bit rd_prev;
   bit track;
   int fmode  [16];
   int rd_cnt [16];
   int de_cnt [16];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (pos %0d)", tag, obs, exp, ppos);
      end
   endtask

   function automatic bit exp_de(input int p);
      return p >= 0 && (p % H_T) < 8 && ((p / H_T) % 7) < 4;
   endfunction
   function automatic bit exp_hs(input int p);
      return p >= 0 && (p % H_T) >= 10 && (p % H_T) < 12;
   endfunction
   function automatic bit exp_vs(input int p);
      return p >= 0 && ((p / H_T) % 7) == 5;
   endfunction
   function automatic bit exp_fs(input int p);
      return p >= 0 && (p % F_T) == 0;
   endfunction
   function automatic logic [23:0] exp_rgb(input int p);
      if (!exp_de(p) || p == uf_target) return 24'h0;
      case (fmode[p / F_T])
         0:       return e565[p % H_T];
         1:       return egray[p % H_T];
         2:       return ebar[p % H_T];
         default: return 24'h0;
      endcase
   endfunction

   // One clock; sample and drive 1 time unit after the rising edge.
   task automatic tick();
      int  cpos;
      bit  rd_exp;
      @(posedge clk);
      #1;
      if (track) begin
         ppos++;
         cpos = ppos + 2;
         if (rd_prev && rd_h < 8) fifo_rd_data = dtab[rd_h];
         rd_exp = cpos >= 0 && exp_de(cpos) && fmode[cpos / F_T] < 2;
         chk("ctl de/hs/vs/fs/rd", {27'd0, de, hs, vs, frame_start, fifo_rd_en},
             {27'd0, exp_de(ppos), exp_hs(ppos), exp_vs(ppos), exp_fs(ppos), rd_exp});
         chk("rgb", {8'd0, rgb_r, rgb_g, rgb_b}, {8'd0, exp_rgb(ppos)});
         if (cpos >= 0 && fifo_rd_en) rd_cnt[cpos / F_T]++;
         if (ppos >= 0 && de) de_cnt[ppos / F_T]++;
         if (frame_start) begin
            if (last_fs >= 0) chk("fs_period", ppos - last_fs, F_T);
            last_fs = ppos;
         end
         fifo_empty = (cpos == uf_target);
         rd_prev    = fifo_rd_en;
         rd_h       = (cpos >= 0) ? cpos % H_T : 0;
      end
   endtask

   task automatic run_to(input int target);
      while (ppos < target) tick();
   endtask

   task automatic restart();
      ppos = -3; uf_target = -1000; last_fs = -1; rd_prev = 1'b0; rd_h = 0;
      for (int i = 0; i < 16; i++) begin
         fmode[i] = 0; rd_cnt[i] = 0; de_cnt[i] = 0;
      end
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; fmt_mode = 2'd0; fifo_rd_data = 16'h0;
      fifo_empty = 1'b0; underflow_clr = 1'b0; track = 1'b0;
      restart();
      repeat (3) tick();
      chk("rst de", de, 1'b0);
      chk("rst rgb", {rgb_r, rgb_g, rgb_b}, 24'h0);
      chk("rst hs/vs", {hs, vs}, 2'b00);
      chk("rst frame_start", frame_start, 1'b0);
      chk("rst underflow", underflow, 1'b0);
      chk("rst rd_en", fifo_rd_en, 1'b0);
      rst_n = 1'b1;
      repeat (4) tick();
      chk("idle outputs", {de, hs, vs, frame_start, fifo_rd_en}, 5'b0);

      // Frames: 0 RGB565, 1 black, 2 colour bar, 3 gray, 4.. RGB565.
      enable = 1'b1; track = 1'b1;
      run_to(2 * H_T);          fmt_mode = 2'd3; fmode[1] = 3;
      run_to(F_T + 10);         fmt_mode = 2'd2; fmode[2] = 2;
      run_to(2 * F_T + 10);     fmt_mode = 2'd1; fmode[3] = 1;
      run_to(3 * F_T + 10);     fmt_mode = 2'd0;
      run_to(4 * F_T);
      chk("reads f0 rgb565", rd_cnt[0], 32);
      chk("reads f1 black", rd_cnt[1], 0);
      chk("reads f2 bar", rd_cnt[2], 0);
      chk("reads f3 gray", rd_cnt[3], 32);
      chk("de f0", de_cnt[0], 32);
      chk("de f2", de_cnt[2], 32);

      // Underflow on pixel (3,1) of frame 4.
      uf_target = 4 * F_T + H_T + 3;
      run_to(uf_target - 1);
      chk("uf before", underflow, 1'b0);
      tick();
      chk("uf set", underflow, 1'b1);
      run_to(5 * F_T + 20);
      chk("uf sticky", underflow, 1'b1);
      underflow_clr = 1'b1;
      tick();
      underflow_clr = 1'b0;
      chk("uf cleared", underflow, 1'b0);

      // Clear coincident with a fresh underflow on pixel (3,2) of frame 5.
      uf_target = 5 * F_T + 2 * H_T + 3;
      run_to(uf_target - 1);
      underflow_clr = 1'b1;
      chk("uf pre-collide", underflow, 1'b0);
      tick();
      underflow_clr = 1'b0;
      chk("uf set beats clr", underflow, 1'b1);

      // Reset at output (10,5) of frame 6: hs and vs both active there.
      run_to(6 * F_T + 5 * H_T + 10);
      rst_n = 1'b0;
      #1;
      chk("async rst hs/vs", {hs, vs}, 2'b00);
      chk("async rst uf", underflow, 1'b0);
      track = 1'b0; fifo_empty = 1'b0;
      repeat (2) tick();
      restart();
      rst_n = 1'b1; track = 1'b1;
      tick();
      tick();
      chk("restart fs early", frame_start, 1'b0);
      tick();
      chk("restart fs", frame_start, 1'b1);

      // Reset mid-line during active video at output (3,1).
      run_to(H_T + 3);
      rst_n = 1'b0;
      #1;
      chk("async rst de", de, 1'b0);
      chk("async rst rgb", {rgb_r, rgb_g, rgb_b}, 24'h0);
      track = 1'b0;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
